// File: rtl/lms_wb_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lms_wb_sequencer                                                         |
// | Wishbone master that streams (x, d) samples through the LMS slave        |
// | register block and returns (y, err) on a valid/ready stream.             |
// | Optional: `define LMS_SEQ_COEF_RD_EN to also read back w0..w3.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lms_wb_sequencer #(
  parameter logic [31:0] BASE_ADR      = 32'h0000_0000,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          TIMEOUT       = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        train_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [15:0] s_x_i,
  input  logic [15:0] s_d_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [15:0] m_y_o,
  output logic [15:0] m_err_o,
`ifdef LMS_SEQ_COEF_RD_EN
  output logic [15:0] m_w0_o,
  output logic [15:0] m_w1_o,
  output logic [15:0] m_w2_o,
  output logic [15:0] m_w3_o,
`endif
  output logic [31:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        bus_err_o,
  input  logic        err_clr_i,
  output logic [15:0] sample_cnt_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WR_MODE = 4'd1,
    WR_D    = 4'd2,
    WR_X    = 4'd3,
    SETTLE  = 4'd4,
    RD_Y    = 4'd5,
    RD_E    = 4'd6,
    OUT     = 4'd7
`ifdef LMS_SEQ_COEF_RD_EN
    ,
    RD_W0   = 4'd8,
    RD_W1   = 4'd9,
    RD_W2   = 4'd10,
    RD_W3   = 4'd11
`endif
  } state_t;

  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] c_to_last     = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_gap;
  logic        r_abort;
  logic [7:0]  r_cnt;
  logic [15:0] r_x, r_d;
  logic        r_train;
  logic        r_mode, r_mode_vld;
  logic        r_s_ready, r_m_valid;
  logic [15:0] r_y, r_err;
  logic [31:0] r_adr;
  logic [15:0] r_dat;
  logic        r_we, r_stb, r_cyc;
  logic        r_bus_err;
  logic [15:0] r_sample_cnt;
`ifdef LMS_SEQ_COEF_RD_EN
  logic [15:0] r_w0, r_w1, r_w2, r_w3;
`endif

  state_t      w_tgt;
  logic        w_launch, w_acc, w_we, w_mode_need, w_train_src;
  logic [31:0] w_adr;
  logic [15:0] w_dat, w_x_src, w_d_src;

  function automatic state_t next_of(input state_t s);
    case (s)
      WR_MODE: next_of = WR_D;
      WR_D:    next_of = WR_X;
      WR_X:    next_of = (SETTLE_CYCLES == 0) ? RD_Y : SETTLE;
      SETTLE:  next_of = RD_Y;
      RD_Y:    next_of = RD_E;
`ifdef LMS_SEQ_COEF_RD_EN
      RD_E:    next_of = RD_W0;
      RD_W0:   next_of = RD_W1;
      RD_W1:   next_of = RD_W2;
      RD_W2:   next_of = RD_W3;
      RD_W3:   next_of = OUT;
`else
      RD_E:    next_of = OUT;
`endif
      default: next_of = IDLE;
    endcase
  endfunction

  // Next access is set up so stb rises on the same edge the previous step ends.
  always_comb begin
    w_mode_need = !r_mode_vld || (r_mode != train_i);
    w_tgt       = next_of(r_state);
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tgt    = w_mode_need ? WR_MODE : WR_D;
        w_launch = s_valid_i && r_s_ready;
      end
      SETTLE:  w_launch = (r_cnt == c_settle_last);
      OUT:     w_launch = 1'b0;
      default: w_launch = r_gap && !r_abort;
    endcase

    w_x_src     = (r_state == IDLE) ? s_x_i   : r_x;
    w_d_src     = (r_state == IDLE) ? s_d_i   : r_d;
    w_train_src = (r_state == IDLE) ? train_i : r_train;

    w_acc = 1'b1;
    w_we  = 1'b0;
    w_adr = BASE_ADR;
    w_dat = 16'h0000;
    case (w_tgt)
      WR_MODE: begin w_we = 1'b1; w_adr = BASE_ADR + 32'h08; w_dat = {15'b0, w_train_src}; end
      WR_D:    begin w_we = 1'b1; w_adr = BASE_ADR + 32'h04; w_dat = w_d_src; end
      WR_X:    begin w_we = 1'b1; w_adr = BASE_ADR;          w_dat = w_x_src; end
      RD_Y:    w_adr = BASE_ADR + 32'h0C;
      RD_E:    w_adr = BASE_ADR + 32'h10;
`ifdef LMS_SEQ_COEF_RD_EN
      RD_W0:   w_adr = BASE_ADR + 32'h14;
      RD_W1:   w_adr = BASE_ADR + 32'h18;
      RD_W2:   w_adr = BASE_ADR + 32'h1C;
      RD_W3:   w_adr = BASE_ADR;
`endif
      default: begin w_acc = 1'b0; w_adr = 32'h0; end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state      <= IDLE;
      r_gap        <= 1'b0;
      r_abort      <= 1'b0;
      r_cnt        <= 8'd0;
      r_x          <= 16'h0;
      r_d          <= 16'h0;
      r_train      <= 1'b0;
      r_mode       <= 1'b0;
      r_mode_vld   <= 1'b0;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_y          <= 16'h0;
      r_err        <= 16'h0;
      r_adr        <= 32'h0;
      r_dat        <= 16'h0;
      r_we         <= 1'b0;
      r_stb        <= 1'b0;
      r_cyc        <= 1'b0;
      r_bus_err    <= 1'b0;
      r_sample_cnt <= 16'h0;
`ifdef LMS_SEQ_COEF_RD_EN
      r_w0 <= 16'h0;
      r_w1 <= 16'h0;
      r_w2 <= 16'h0;
      r_w3 <= 16'h0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (err_clr_i) r_bus_err <= 1'b0;
          if (w_launch) begin
            r_x       <= s_x_i;
            r_d       <= s_d_i;
            r_train   <= train_i;
            r_s_ready <= 1'b0;
          end else begin
            r_s_ready <= !r_bus_err || err_clr_i;
          end
        end
        SETTLE: if (!w_launch) r_cnt <= r_cnt + 8'd1;
        OUT: begin
          if (m_ready_i) begin
            r_m_valid    <= 1'b0;
            r_sample_cnt <= r_sample_cnt + 16'd1;
            r_state      <= IDLE;
            r_s_ready    <= 1'b1;
          end
        end
        default: begin
          if (r_gap) begin
            // Gap cycle: the slave's trailing ack is deliberately ignored here.
            r_gap <= 1'b0;
            if (r_abort) begin
              r_abort <= 1'b0;
              r_state <= IDLE;
            end
          end else if (wb_ack_i || r_cnt == c_to_last) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= 32'h0;
            r_dat <= 16'h0;
            r_gap <= 1'b1;
            if (wb_ack_i) begin
              case (r_state)
                WR_MODE: begin r_mode <= r_train; r_mode_vld <= 1'b1; end
                RD_Y:    r_y   <= wb_dat_i;
                RD_E:    r_err <= wb_dat_i;
`ifdef LMS_SEQ_COEF_RD_EN
                RD_W0:   r_w0 <= wb_dat_i;
                RD_W1:   r_w1 <= wb_dat_i;
                RD_W2:   r_w2 <= wb_dat_i;
                RD_W3:   r_w3 <= wb_dat_i;
`endif
                default: ;
              endcase
            end else begin
              r_abort    <= 1'b1;
              r_bus_err  <= 1'b1;
              r_mode_vld <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase

      if (w_launch) begin
        r_state <= w_tgt;
        r_cnt   <= 8'd0;
        if (w_acc) begin
          r_cyc <= 1'b1;
          r_stb <= 1'b1;
          r_we  <= w_we;
          r_adr <= w_adr;
          r_dat <= w_dat;
        end
        if (w_tgt == OUT) r_m_valid <= 1'b1;
      end
    end
  end

  assign s_ready_o    = r_s_ready;
  assign m_valid_o    = r_m_valid;
  assign m_y_o        = r_y;
  assign m_err_o      = r_err;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_we_o      = r_we;
  assign wb_stb_o     = r_stb;
  assign wb_cyc_o     = r_cyc;
  assign bus_err_o    = r_bus_err;
  assign sample_cnt_o = r_sample_cnt;
`ifdef LMS_SEQ_COEF_RD_EN
  assign m_w0_o = r_w0;
  assign m_w1_o = r_w1;
  assign m_w2_o = r_w2;
  assign m_w3_o = r_w3;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lms_wb_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lms_wb_sequencer                                                      |
// | Self-checking bench: Wishbone slave model plus transaction-level model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lms_wb_sequencer;
  localparam int SETTLE = 2;
  localparam int TMO    = 16;
`ifdef LMS_SEQ_COEF_RD_EN
  localparam int COEF_LAT = 12;
`else
  localparam int COEF_LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, train, s_valid, s_ready, m_valid, m_ready;
  logic        we, stb, cyc, ack, bus_err, err_clr;
  logic [15:0] s_x, s_d, m_y, m_err, dat_o, dat_i, cnt;
  logic [31:0] adr;
`ifdef LMS_SEQ_COEF_RD_EN
  logic [15:0] w0, w1, w2, w3;
`endif

  logic [15:0] sl_y, sl_err;
  logic [15:0] sl_w [4];
  bit          withhold_d;
  logic        prev_acc;
  int          gap_viol = 0;

  typedef struct packed {logic we; logic [31:0] adr; logic [15:0] dat;} txn_t;
  txn_t log_q[$];
  txn_t exp_q[$];

  int          errors = 0;
  int          checks = 0;
  bit          mdl_mode_known;
  logic        mdl_mode;
  logic [15:0] exp_cnt;

  lms_wb_sequencer #(.BASE_ADR(32'h0), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .train_i(train),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_x_i(s_x), .s_d_i(s_d),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_y_o(m_y), .m_err_o(m_err),
`ifdef LMS_SEQ_COEF_RD_EN
    .m_w0_o(w0), .m_w1_o(w1), .m_w2_o(w2), .m_w3_o(w3),
`endif
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_we_o(we),
    .wb_stb_o(stb), .wb_cyc_o(cyc), .wb_ack_i(ack),
    .bus_err_o(bus_err), .err_clr_i(err_clr), .sample_cnt_o(cnt)
  );

  // Slave: registered ack held while stb is high, read data decoded from address.
  always @(posedge clk) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      prev_acc <= 1'b0;
    end else begin
      ack      <= stb && cyc && !(withhold_d && we && adr[7:0] == 8'h04);
      prev_acc <= stb && ack;
      if (prev_acc && stb) gap_viol <= gap_viol + 1;
      if (stb && ack) log_q.push_back({we, adr, we ? dat_o : dat_i});
    end
  end

  always_comb begin
    case (adr[7:0])
      8'h0C:   dat_i = sl_y;
      8'h10:   dat_i = sl_err;
      8'h14:   dat_i = sl_w[0];
      8'h18:   dat_i = sl_w[1];
      8'h1C:   dat_i = sl_w[2];
      8'h00:   dat_i = sl_w[3];
      default: dat_i = 16'h0;
    endcase
  end

  // Expected bus transfers and latency for one sample, from the register map.
  task automatic model_sample(input logic [15:0] x, input logic [15:0] d, input logic tr,
                              output int lat);
    exp_q.delete();
    lat = 12 + SETTLE + COEF_LAT;
    if (!mdl_mode_known || mdl_mode != tr) begin
      exp_q.push_back({1'b1, 32'h08, 15'b0, tr});
      lat += 3;
      mdl_mode_known = 1'b1;
      mdl_mode       = tr;
    end
    exp_q.push_back({1'b1, 32'h04, d});
    exp_q.push_back({1'b1, 32'h00, x});
    exp_q.push_back({1'b0, 32'h0C, sl_y});
    exp_q.push_back({1'b0, 32'h10, sl_err});
`ifdef LMS_SEQ_COEF_RD_EN
    exp_q.push_back({1'b0, 32'h14, sl_w[0]});
    exp_q.push_back({1'b0, 32'h18, sl_w[1]});
    exp_q.push_back({1'b0, 32'h1C, sl_w[2]});
    exp_q.push_back({1'b0, 32'h00, sl_w[3]});
`endif
  endtask

  task automatic offer_and_accept(input logic [15:0] x, input logic [15:0] d, input logic tr);
    int n;
    @(negedge clk);
    s_x = x; s_d = d; train = tr; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    log_q.delete();
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] x, input logic [15:0] d, input logic tr,
                             input logic [15:0] y, input logic [15:0] e, input int rdly);
    int lat_exp, lat, bad;
    sl_y = y; sl_err = e;
    model_sample(x, d, tr, lat_exp);
    offer_and_accept(x, d, tr);
    lat = 0;
    while (!m_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != lat_exp) begin errors++; $display("FAIL latency: got %0d cycles, expected %0d", lat, lat_exp); end
    checks++;
    if (m_y !== y) begin errors++; $display("FAIL m_y: got %h expected %h", m_y, y); end
    checks++;
    if (m_err !== e) begin errors++; $display("FAIL m_err: got %h expected %h", m_err, e); end
    repeat (rdly) begin
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_y !== y || m_err !== e) begin
        errors++; $display("FAIL hold: valid=%b y=%h err=%h, expected 1 %h %h", m_valid, m_y, m_err, y, e);
      end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    exp_cnt++;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b expected 0", m_valid); end
    checks++;
    if (cnt !== exp_cnt) begin errors++; $display("FAIL sample_cnt: got %0d expected %0d", cnt, exp_cnt); end
    checks++;
    bad = -1;
    if (log_q.size() == exp_q.size())
      foreach (exp_q[i]) if (bad < 0 && log_q[i] !== exp_q[i]) bad = i;
    if (log_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bus_seq_len: got %0d transfers expected %0d", log_q.size(), exp_q.size());
    end else if (bad >= 0) begin
      errors++; $display("FAIL bus_seq[%0d]: got %h expected %h (we,adr,dat)", bad, log_q[bad], exp_q[bad]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL rst_stream: s_ready=%b m_valid=%b expected 0 0", s_ready, m_valid);
    end
    checks++;
    if (cyc !== 1'b0 || stb !== 1'b0 || we !== 1'b0) begin
      errors++; $display("FAIL rst_bus: cyc=%b stb=%b we=%b expected 0 0 0", cyc, stb, we);
    end
    checks++;
    if (adr !== 32'h0 || dat_o !== 16'h0) begin
      errors++; $display("FAIL rst_adr_dat: adr=%h dat=%h expected 0 0", adr, dat_o);
    end
    checks++;
    if (bus_err !== 1'b0 || cnt !== 16'h0 || m_y !== 16'h0 || m_err !== 16'h0) begin
      errors++; $display("FAIL rst_regs: bus_err=%b cnt=%h y=%h err=%h expected all 0", bus_err, cnt, m_y, m_err);
    end
    rst_n = 1'b1;
    mdl_mode_known = 1'b0;
    exp_cnt = 16'h0;
  endtask

  task automatic test_single;
    send_sample(16'h0100, 16'h0200, 1'b1, 16'h0040, 16'h01C0, 0);
  endtask

  task automatic test_second;
    send_sample(16'h0123, 16'hFF00, 1'b1, 16'h7FFF, 16'h8000, 1);
  endtask

  task automatic test_back_to_back;
    int lat_exp, lat;
    sl_y = 16'h1111; sl_err = 16'h2222;
    model_sample(16'h0AAA, 16'h0CCC, 1'b1, lat_exp);
    offer_and_accept(16'h0AAA, 16'h0CCC, 1'b1);
    s_x = 16'h0BBB; s_d = 16'h0DDD; s_valid = 1'b1;
    lat = 0;
    while (!m_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != lat_exp) begin errors++; $display("FAIL b2b_latency_a: got %0d expected %0d", lat, lat_exp); end
    sl_y = 16'h3333; sl_err = 16'h4444;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_y !== 16'h1111 || m_err !== 16'h2222 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold: valid=%b y=%h err=%h s_ready=%b expected 1 1111 2222 0", m_valid, m_y, m_err, s_ready);
      end
    end
    model_sample(16'h0BBB, 16'h0DDD, 1'b1, lat_exp);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    exp_cnt++;
    log_q.delete();
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != lat_exp) begin errors++; $display("FAIL b2b_latency_b: got %0d expected %0d", lat, lat_exp); end
    checks++;
    if (m_y !== 16'h3333 || m_err !== 16'h4444) begin
      errors++; $display("FAIL b2b_data_b: y=%h err=%h expected 3333 4444", m_y, m_err);
    end
    checks++;
    if (log_q.size() < 2 || log_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL b2b_x_write: got %0d transfers, expected x write %h", log_q.size(), exp_q[1]);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    exp_cnt++;
    checks++;
    if (cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      send_sample(16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 3)));
  endtask

  task automatic test_timeout;
    int n, hi;
    bit bad_valid, bad_ready;
    withhold_d = 1'b1;
    offer_and_accept(16'h0555, 16'h0666, 1'b1);
    n = 0;
    while (!(stb && adr[7:0] == 8'h04) && n < 100) begin @(posedge clk); #1; n++; end
    hi = 0;
    while (stb && hi < 100) begin hi++; @(posedge clk); #1; end
    checks++;
    if (hi != TMO) begin errors++; $display("FAIL timeout_len: stb high %0d cycles expected %0d", hi, TMO); end
    checks++;
    if (bus_err !== 1'b1 || cyc !== 1'b0) begin
      errors++; $display("FAIL timeout_flag: bus_err=%b cyc=%b expected 1 0", bus_err, cyc);
    end
    withhold_d = 1'b0;
    mdl_mode_known = 1'b0;
    bad_valid = 1'b0; bad_ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b0) bad_valid = 1'b1;
      if (s_ready !== 1'b0) bad_ready = 1'b1;
    end
    checks++;
    if (bad_valid) begin errors++; $display("FAIL timeout_no_out: m_valid seen 1 expected 0"); end
    checks++;
    if (bad_ready) begin errors++; $display("FAIL timeout_ready: s_ready seen 1 expected 0"); end
    checks++;
    if (cnt !== exp_cnt) begin errors++; $display("FAIL timeout_cnt: got %0d expected %0d", cnt, exp_cnt); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL err_clr: bus_err=%b expected 0", bus_err); end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL err_clr_ready: got %b expected 1", s_ready); end
    send_sample(16'h0777, 16'h0888, 1'b1, 16'h0999, 16'h0AAA, 0);
  endtask

  task automatic test_reset_mid;
    int n;
    sl_y = 16'h1234; sl_err = 16'h5678;
    offer_and_accept(16'h0011, 16'h0022, 1'b0);
    n = 0;
    while (!(stb && adr[7:0] == 8'h0C) && n < 100) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cyc !== 1'b0 || stb !== 1'b0 || m_valid !== 1'b0 || cnt !== 16'h0) begin
      errors++; $display("FAIL reset_mid: cyc=%b stb=%b m_valid=%b cnt=%0d expected all 0", cyc, stb, m_valid, cnt);
    end
    rst_n = 1'b1;
    mdl_mode_known = 1'b0;
    exp_cnt = 16'h0;
    send_sample(16'h0033, 16'h0044, mdl_mode, 16'h0055, 16'h0066, 0);
  endtask

`ifdef LMS_SEQ_COEF_RD_EN
  task automatic test_coef;
    sl_w[0] = 16'd1; sl_w[1] = 16'd2; sl_w[2] = 16'd3; sl_w[3] = 16'd4;
    send_sample(16'h0100, 16'h0200, 1'b1, 16'h0040, 16'h01C0, 0);
    checks++;
    if (w0 !== 16'd1 || w1 !== 16'd2 || w2 !== 16'd3 || w3 !== 16'd4) begin
      errors++; $display("FAIL coef: got %h %h %h %h expected 1 2 3 4", w0, w1, w2, w3);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; train = 1'b0; s_valid = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    s_x = 16'h0; s_d = 16'h0; withhold_d = 1'b0;
    sl_y = 16'h0; sl_err = 16'h0;
    sl_w[0] = 16'h0; sl_w[1] = 16'h0; sl_w[2] = 16'h0; sl_w[3] = 16'h0;
    mdl_mode_known = 1'b0; mdl_mode = 1'b0; exp_cnt = 16'h0;
    test_reset;
    test_single;
    test_second;
    test_back_to_back;
    test_random;
    test_timeout;
    test_reset_mid;
`ifdef LMS_SEQ_COEF_RD_EN
    test_coef;
`endif
    checks++;
    if (gap_viol != 0) begin errors++; $display("FAIL gap_cycle: %0d accesses without gap, expected 0", gap_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
